// File: rtl/rc_channel_conditioner_if.sv
// Bus bundle for rc_channel_conditioner: frame request, packed channel values and frame status.
// Handshake: a 0->1 edge on start_signal requests one frame (at most one more can queue while busy);
// values_in must stay stable until complete_signal, whose one-cycle pulse marks values_out valid.
interface rc_channel_conditioner_if #(
  parameter int NUM_CH = 4,
  parameter int VAL_W  = 8
);
  logic                    start_signal;
  logic [NUM_CH*VAL_W-1:0] values_in;
  logic [NUM_CH*VAL_W-1:0] values_out;
  logic                    active_signal;
  logic                    complete_signal;
  logic                    failsafe_signal;
  logic [2:0]              dbg_state;

  modport master (
    output start_signal, values_in,
    input  values_out, active_signal, complete_signal, failsafe_signal, dbg_state
  );

  modport slave (
    input  start_signal, values_in,
    output values_out, active_signal, complete_signal, failsafe_signal, dbg_state
  );
endinterface

// File: rtl/rc_channel_conditioner.sv
// Serial multi-channel RC value conditioner: clamp, idle de-glitch, 3-segment scaling, slew limit.
// Optional receiver-loss failsafe is compiled in with `define RC_FAILSAFE_EN.
module rc_channel_conditioner #(
  parameter int NUM_CH     = 4,
  parameter int VAL_W      = 8,
  parameter int OPS_W      = 16,
  parameter int IDLE_THR   = 10,
  parameter int MAX_VAL    = 250,
  parameter int LOW_BP     = 42,
  parameter int HIGH_BP    = 209,
  parameter int HIGH_OFF   = 252,
  parameter int MID_OFF    = 61,
  parameter int SLEW_LIM   = 20,
  parameter int FS_TIMEOUT = 100000
) (
  input  logic                    us_clk,
  input  logic                    resetn,
  rc_channel_conditioner_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic signed [OPS_W-1:0] ops_t;
  typedef logic [VAL_W-1:0]        val_t;

  localparam ops_t IDLE_S = ops_t'(IDLE_THR);
  localparam ops_t MAX_S  = ops_t'(MAX_VAL);
  localparam ops_t LOW_S  = ops_t'(LOW_BP);
  localparam ops_t HIGH_S = ops_t'(HIGH_BP);
  localparam ops_t HOFF_S = ops_t'(HIGH_OFF);
  localparam ops_t MOFF_S = ops_t'(MID_OFF);
  localparam ops_t SLEW_S = ops_t'(SLEW_LIM);
  localparam val_t IDLE_V = val_t'(IDLE_THR);
  localparam val_t MAX_V  = val_t'(MAX_VAL);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_DEGLITCH, S_SCALE, S_LIMIT, S_STORE, S_COMPLETE
  } state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  ops_t                    work_q, work_d;
  logic                    start_prev_q;
  logic                    start_flag_q, start_flag_d;
  val_t                    latched_q [NUM_CH];
  val_t                    latched_d [NUM_CH];
  val_t                    prev_in_q [NUM_CH];
  val_t                    prev_in_d [NUM_CH];
  val_t                    prev_out_q[NUM_CH];
  val_t                    prev_out_d[NUM_CH];
  val_t                    shadow_q  [NUM_CH];
  val_t                    shadow_d  [NUM_CH];
  logic [NUM_CH*VAL_W-1:0] values_out_q, values_out_d;
  logic                    start_rise;
  ops_t                    prev_ext, slew_up, slew_dn;

  function automatic ops_t ext(input val_t v);
    return ops_t'({1'b0, v});
  endfunction

  assign start_rise = bus.start_signal & ~start_prev_q;
  assign prev_ext   = ext(prev_out_q[ch_q]);
  assign slew_up    = prev_ext + SLEW_S;
  assign slew_dn    = prev_ext - SLEW_S;

`ifdef RC_FAILSAFE_EN
  localparam int FS_CW = $clog2(FS_TIMEOUT + 1);
  localparam logic [FS_CW-1:0] FS_MAX = FS_CW'(FS_TIMEOUT);
  logic [FS_CW-1:0] fs_cnt_q, fs_cnt_d;
  logic             failsafe_q, failsafe_d;
`endif

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    work_d       = work_q;
    start_flag_d = start_flag_q;
    latched_d    = latched_q;
    prev_in_d    = prev_in_q;
    prev_out_d   = prev_out_q;
    shadow_d     = shadow_q;
    values_out_d = values_out_q;
    case (state_q)
      S_IDLE: begin
        if (start_flag_q) begin
          state_d      = S_LATCH;
          start_flag_d = 1'b0;
        end
      end
      S_LATCH: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (bus.values_in[k*VAL_W +: VAL_W] < IDLE_V)      latched_d[k] = '0;
          else if (bus.values_in[k*VAL_W +: VAL_W] > MAX_V)  latched_d[k] = MAX_V;
          else                                               latched_d[k] = bus.values_in[k*VAL_W +: VAL_W];
        end
        ch_d    = '0;
        state_d = S_DEGLITCH;
      end
      S_DEGLITCH: begin
        // A single idle frame after activity reuses the last input; a second one gets through.
        if (latched_q[ch_q] <= IDLE_V && prev_in_q[ch_q] > IDLE_V) work_d = ext(prev_in_q[ch_q]);
        else                                                       work_d = ext(latched_q[ch_q]);
        prev_in_d[ch_q] = latched_q[ch_q];
        state_d         = S_SCALE;
      end
      S_SCALE: begin
        if (work_q < LOW_S)       work_d = work_q + work_q;
        else if (work_q > HIGH_S) work_d = work_q + work_q - HOFF_S;
        else                      work_d = (work_q >>> 1) + MOFF_S;
        state_d = S_LIMIT;
      end
      S_LIMIT: begin
        if (work_q < IDLE_S)             work_d = '0;
        else if (work_q > slew_up)       work_d = (slew_up > MAX_S) ? MAX_S : slew_up;
        else if (prev_ext > work_q + SLEW_S) work_d = (slew_dn < IDLE_S) ? '0 : slew_dn;
        else if (work_q > MAX_S)         work_d = MAX_S;
        state_d = S_STORE;
      end
      S_STORE: begin
        shadow_d[ch_q] = work_q[VAL_W-1:0];
        if (ch_q == LAST_CH) begin
          // All channels publish together on entry to COMPLETE, aligned with the pulse.
          for (int k = 0; k < NUM_CH; k++) values_out_d[k*VAL_W +: VAL_W] = shadow_d[k];
          prev_out_d = shadow_d;
          state_d    = S_COMPLETE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_DEGLITCH;
        end
      end
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (start_rise) start_flag_d = 1'b1;
`ifdef RC_FAILSAFE_EN
    fs_cnt_d   = fs_cnt_q;
    failsafe_d = failsafe_q;
    if (start_rise) begin
      fs_cnt_d   = '0;
      failsafe_d = 1'b0;
    end else begin
      if (fs_cnt_q != FS_MAX) fs_cnt_d = fs_cnt_q + 1'b1;
      if (fs_cnt_q == FS_MAX && state_q == S_IDLE && !start_flag_q) begin
        values_out_d = '0;
        prev_out_d   = '{default: '0};
        prev_in_d    = '{default: '0};
        failsafe_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      work_q       <= '0;
      start_prev_q <= 1'b0;
      start_flag_q <= 1'b0;
      latched_q    <= '{default: '0};
      prev_in_q    <= '{default: '0};
      prev_out_q   <= '{default: '0};
      shadow_q     <= '{default: '0};
      values_out_q <= '0;
`ifdef RC_FAILSAFE_EN
      fs_cnt_q     <= '0;
      failsafe_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      work_q       <= work_d;
      start_prev_q <= bus.start_signal;
      start_flag_q <= start_flag_d;
      latched_q    <= latched_d;
      prev_in_q    <= prev_in_d;
      prev_out_q   <= prev_out_d;
      shadow_q     <= shadow_d;
      values_out_q <= values_out_d;
`ifdef RC_FAILSAFE_EN
      fs_cnt_q     <= fs_cnt_d;
      failsafe_q   <= failsafe_d;
`endif
    end
  end

  assign bus.values_out      = values_out_q;
  assign bus.active_signal   = (state_q != S_IDLE) && (state_q != S_COMPLETE);
  assign bus.complete_signal = (state_q == S_COMPLETE);
  assign bus.dbg_state       = state_q;
`ifdef RC_FAILSAFE_EN
  assign bus.failsafe_signal = failsafe_q;
`else
  wire unused_fs_timeout = (FS_TIMEOUT != 0);
  assign bus.failsafe_signal = 1'b0;
`endif
endmodule

// File: tb/tb_rc_channel_conditioner.sv
// Randomized bench for rc_channel_conditioner, checked against an integer reference model of the
// conditioning rules; covers scaling, slew ramp, clamps, start queuing, mid-frame reset, failsafe.
module tb_rc_channel_conditioner;
  localparam int NUM_CH = 4;
  localparam int VAL_W  = 8;
  localparam int W      = NUM_CH * VAL_W;

  logic us_clk;
  logic resetn;

  rc_channel_conditioner_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W)) bus ();

  rc_channel_conditioner #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .FS_TIMEOUT(1000)) dut (
    .us_clk(us_clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    us_clk = 1'b0;
    forever #5 us_clk = ~us_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks;
  int n_fail;
  int stim       [NUM_CH];
  int m_prev_in  [NUM_CH];
  int m_prev_out [NUM_CH];
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model: one whole frame, straight from the conditioning rules
  function automatic logic [W-1:0] model_frame();
    logic [W-1:0] o;
    int nxt[NUM_CH];
    int c, d, s, p, r;
    o = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      c = (stim[ch] < 10) ? 0 : (stim[ch] > 250) ? 250 : stim[ch];
      d = (c <= 10 && m_prev_in[ch] > 10) ? m_prev_in[ch] : c;
      m_prev_in[ch] = c;
      if (d < 42)       s = 2 * d;
      else if (d > 209) s = 2 * d - 252;
      else              s = d / 2 + 61;
      p = m_prev_out[ch];
      if (s < 10)           r = 0;
      else if (s > p + 20)  r = (p + 20 > 250) ? 250 : p + 20;
      else if (p > s + 20)  r = (p - 20 < 10) ? 0 : p - 20;
      else                  r = (s > 250) ? 250 : s;
      nxt[ch] = r;
      o[ch*VAL_W +: VAL_W] = r[VAL_W-1:0];
    end
    m_prev_out = nxt;
    return o;
  endfunction

  function automatic void model_clear();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_prev_in[ch]  = 0;
      m_prev_out[ch] = 0;
    end
  endfunction

  // driver tasks
  task automatic drive_values();
    for (int k = 0; k < NUM_CH; k++) bus.values_in[k*VAL_W +: VAL_W] = stim[k][VAL_W-1:0];
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    bus.start_signal = 1'b0;
    repeat (3) @(posedge us_clk);
    @(negedge us_clk);
    resetn = 1'b1;
    model_clear();
    exp_q.delete();
  endtask

  task automatic compare_out(input string tag, input logic [W-1:0] exp_v);
    for (int k = 0; k < NUM_CH; k++)
      check_val($sformatf("%s_ch%0d", tag, k), bus.values_out[k*VAL_W +: VAL_W], exp_v[k*VAL_W +: VAL_W]);
  endtask

  task automatic run_frame(input string tag);
    logic [W-1:0] exp_v;
    int  lat;
    bit  seen;
    exp_q.push_back(model_frame());
    drive_values();
    bus.start_signal = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge us_clk); #1;
      if (n == 0) bus.start_signal = 1'b0;
      if (n == 5) check_val({tag, "_active"}, bus.active_signal, 1);
      if (bus.complete_signal) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
    end
    check_val({tag, "_done"}, seen, 1);
    exp_v = exp_q.pop_front();
    if (seen) begin
      check_val({tag, "_latency"}, lat, 18);
      compare_out(tag, exp_v);
      @(posedge us_clk); #1;
      check_val({tag, "_pulse_end"}, bus.complete_signal, 0);
      check_val({tag, "_idle"}, bus.active_signal, 0);
    end
  endtask

  initial begin
    logic [W-1:0] exp_v;
    int ncomp;
    n_checks = 0;
    n_fail   = 0;
    bus.start_signal = 1'b0;
    bus.values_in    = '0;
    for (int k = 0; k < NUM_CH; k++) stim[k] = 0;
    apply_reset();

    @(posedge us_clk); #1;
    check_val("rst_values_out", bus.values_out, 0);
    check_val("rst_active", bus.active_signal, 0);
    check_val("rst_complete", bus.complete_signal, 0);
    check_val("rst_failsafe", bus.failsafe_signal, 0);

    // scaling, after the slew limiter has settled onto the targets
    stim = '{20, 100, 230, 250};
    for (int f = 0; f < 14; f++) run_frame("t1");
    check_val("t1_seg_low", bus.values_out[7:0], 40);
    check_val("t1_seg_mid", bus.values_out[15:8], 111);
    check_val("t1_seg_high", bus.values_out[23:16], 208);
    check_val("t1_seg_max", bus.values_out[31:24], 248);

    // slew ramp from reset, then idle hold and drop
    apply_reset();
    stim = '{200, 0, 0, 0};
    for (int f = 1; f <= 9; f++) begin
      run_frame("t2_ramp");
      check_val("t2_ramp_val", bus.values_out[7:0], (20 * f > 161) ? 161 : 20 * f);
    end
    stim[0] = 5;
    run_frame("t2_hold");
    check_val("t2_hold_val", bus.values_out[7:0], 161);
    run_frame("t2_drop");
    check_val("t2_drop_val", bus.values_out[7:0], 0);

    // clamps
    stim = '{255, 9, 10, 251};
    run_frame("t3");
    check_val("t3_idle_in", bus.values_out[15:8], 0);
    run_frame("t3b");

    // start edges while busy: one queued frame, extra edge dropped
    stim = '{60, 120, 180, 240};
    exp_q.push_back(model_frame());
    exp_q.push_back(model_frame());
    drive_values();
    bus.start_signal = 1'b1;
    ncomp = 0;
    for (int n = 0; n < 90; n++) begin
      @(posedge us_clk); #1;
      case (n)
        0, 6, 10: bus.start_signal = 1'b0;
        5, 9:     bus.start_signal = 1'b1;
        default: ;
      endcase
      if (bus.complete_signal) begin
        ncomp++;
        if (ncomp == 1) check_val("t4_first_time", n, 18);
        if (ncomp == 2) check_val("t4_second_time", n, 37);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          compare_out("t4", exp_v);
        end
      end
    end
    check_val("t4_num_complete", ncomp, 2);
    check_val("t4_queue_empty", exp_q.size(), 0);

    // reset in the middle of a frame
    stim = '{100, 200, 30, 250};
    drive_values();
    bus.start_signal = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge us_clk); #1;
      if (n == 0) bus.start_signal = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check_val("t5_values_out", bus.values_out, 0);
    check_val("t5_active", bus.active_signal, 0);
    check_val("t5_complete", bus.complete_signal, 0);
    @(negedge us_clk);
    resetn = 1'b1;
    model_clear();
    ncomp = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge us_clk); #1;
      if (bus.complete_signal) ncomp++;
    end
    check_val("t5_no_complete", ncomp, 0);
    run_frame("t5_after");

    // randomized frames, biased toward the idle threshold and the ceiling
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        case ($urandom_range(0, 3))
          0:       stim[k] = $urandom_range(0, 14);
          1:       stim[k] = $urandom_range(240, 255);
          default: stim[k] = $urandom_range(0, 255);
        endcase
      end
      run_frame("rnd");
      check_val("rnd_failsafe", bus.failsafe_signal, 0);
    end

`ifdef RC_FAILSAFE_EN
    stim = '{178, 178, 178, 178};
    for (int f = 0; f < 9; f++) run_frame("t6_settle");
    check_val("t6_level", bus.values_out[7:0], 150);
    repeat (1100) @(posedge us_clk);
    #1;
    check_val("t6_fs_values", bus.values_out, 0);
    check_val("t6_fs_flag", bus.failsafe_signal, 1);
    check_val("t6_fs_no_pulse", bus.complete_signal, 0);
    model_clear();
    run_frame("t6_recover");
    check_val("t6_fs_cleared", bus.failsafe_signal, 0);
    check_val("t6_ramp_first", bus.values_out[7:0], 20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
